// File: rtl/bsg_up_pkg.sv
// rtl/bsg_up_pkg.sv - shared types and defaults for the upstream io channel
package bsg_up_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HI   = 1'b1
  } state_e;

  localparam int WORD_W_DEF         = 16;
  localparam int IO_W_DEF           = 8;
  localparam int CREDITS_DEF        = 64;
  localparam int TOKEN_DECIMATE_DEF = 4;

  // Counter must represent 0..credits inclusive.
  function automatic int calc_cw(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/bsg_up_credit_counter.sv
// rtl/bsg_up_credit_counter.sv - token edge detect and saturating credit counter
module bsg_up_credit_counter
  import bsg_up_pkg::*;
#(
  parameter int CREDITS        = CREDITS_DEF,
  parameter int TOKEN_DECIMATE = TOKEN_DECIMATE_DEF,
  parameter int CW             = calc_cw(CREDITS_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spend_i,
  input  logic          io_token_i,
  output logic [CW-1:0] credit_o,
  output logic          credit_err_o
);

  localparam logic [CW:0] CREDITS_X  = (CW + 1)'(CREDITS);
  localparam logic [CW:0] DECIMATE_X = (CW + 1)'(TOKEN_DECIMATE);

  logic [CW-1:0] credit_q, credit_d;
  logic          err_q, err_d;
  logic          token_r_q, token_r_d;
  logic          token_edge;
  logic [CW:0]   sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q  <= CREDITS_X[CW-1:0];
      err_q     <= 1'b0;
      token_r_q <= 1'b0;
    end else begin
      credit_q  <= credit_d;
      err_q     <= err_d;
      token_r_q <= token_r_d;
    end
  end

  // One extra bit so a return that overshoots CREDITS is visible before clamping.
  always_comb begin
    token_edge = io_token_i ^ token_r_q;
    token_r_d  = io_token_i;
    sum        = {1'b0, credit_q} + (token_edge ? DECIMATE_X : '0) - {{CW{1'b0}}, spend_i};
    credit_d   = sum[CW-1:0];
    err_d      = err_q;
    if (sum > CREDITS_X) begin
      credit_d = CREDITS_X[CW-1:0];
      err_d    = 1'b1;
    end
  end

  assign credit_o     = credit_q;
  assign credit_err_o = err_q;

endmodule

// File: rtl/bsg_upstream_io_ch.sv
// rtl/bsg_upstream_io_ch.sv - serialises 16-bit core words into credit-gated 8-bit io beats
module bsg_upstream_io_ch
  import bsg_up_pkg::*;
#(
  parameter int WORD_W         = WORD_W_DEF,
  parameter int IO_W           = IO_W_DEF,
  parameter int CREDITS        = CREDITS_DEF,
  parameter int TOKEN_DECIMATE = TOKEN_DECIMATE_DEF,
  localparam int CW            = calc_cw(CREDITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] core_data_i,
  input  logic              core_valid_i,
  output logic              core_yumi_o,
  input  logic              io_token_i,
  output logic [IO_W-1:0]   io_data_o,
  output logic              io_valid_o,
  output logic [CW-1:0]     credit_o,
  output logic              credit_err_o
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [IO_W-1:0]     io_data_q, io_data_d;
  logic                io_valid_q, io_valid_d;
  logic                yumi;

  bsg_up_credit_counter #(
    .CREDITS       (CREDITS),
    .TOKEN_DECIMATE(TOKEN_DECIMATE),
    .CW            (CW)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .spend_i     (yumi),
    .io_token_i  (io_token_i),
    .credit_o    (credit_o),
    .credit_err_o(credit_err_o)
  );

  // A word is taken only while the pins are free for the following two cycles.
  assign yumi = core_valid_i && (credit_o != '0) && !rst && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      io_data_q  <= '0;
      io_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      io_data_q  <= io_data_d;
      io_valid_q <= io_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (yumi) state_d = HI;
      HI:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_d     = hold_q;
    io_data_d  = io_data_q;
    io_valid_d = 1'b0;
    if (state_q == HI) begin
      io_data_d  = hold_q[WORD_W-1:IO_W];
      io_valid_d = 1'b1;
    end else if (yumi) begin
      hold_d     = core_data_i;
      io_data_d  = core_data_i[IO_W-1:0];
      io_valid_d = 1'b1;
    end
  end

  assign core_yumi_o = yumi;
  assign io_data_o   = io_data_q;
  assign io_valid_o  = io_valid_q;

endmodule

// File: tb/tb_bsg_upstream_io_ch.sv
// tb/tb_bsg_upstream_io_ch.sv - scoreboard bench for the upstream io channel
module tb_bsg_upstream_io_ch;

  localparam int CREDITS = 64;
  localparam int DEC     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] core_data_i = '0;
  logic        core_valid_i = 1'b0;
  logic        core_yumi_o;
  logic        io_token_i = 1'b0;
  logic [7:0]  io_data_o;
  logic        io_valid_o;
  logic [6:0]  credit_o;
  logic        credit_err_o;

  bsg_upstream_io_ch dut (
    .clk         (clk),
    .rst         (rst),
    .core_data_i (core_data_i),
    .core_valid_i(core_valid_i),
    .core_yumi_o (core_yumi_o),
    .io_token_i  (io_token_i),
    .io_data_o   (io_data_o),
    .io_valid_o  (io_valid_o),
    .credit_o    (credit_o),
    .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic [7:0] b;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  bit    mon_en = 0;

  // Reference model: credits as a plain integer, pins modelled as the first cycle free for a new word.
  int    m_credit = CREDITS;
  bit    m_err    = 0;
  bit    m_tok    = 0;
  int    m_free   = 0;
  bit    m_acc    = 0;
  bit    m_known  = 0;
  bit    tok_lvl  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit v, input logic [15:0] d, input bit tok, input bit r);
    beat_t keep[$];
    int    nc;
    bit    edge_seen;
    @(posedge clk);
    cyc++;
    #1;
    core_valid_i = v;
    core_data_i  = d;
    io_token_i   = tok;
    rst          = r;
    #1;
    m_acc = v && !r && (m_credit > 0) && (m_free <= cyc);
    chk("yumi", int'(core_yumi_o), int'(m_acc));
    if (m_known) begin
      chk("credit", int'(credit_o), m_credit);
      chk("credit_err", int'(credit_err_o), int'(m_err));
    end
    edge_seen = (tok != m_tok);
    if (r) begin
      m_credit = CREDITS;
      m_err    = 0;
      m_tok    = 0;
      m_free   = 0;
      m_known  = 1;
      foreach (exp_q[i]) if (exp_q[i].cyc <= cyc) keep.push_back(exp_q[i]);
      exp_q = keep;
    end else begin
      nc = m_credit + (edge_seen ? DEC : 0) - (m_acc ? 1 : 0);
      if (nc > CREDITS) begin
        nc    = CREDITS;
        m_err = 1;
      end
      m_credit = nc;
      m_tok    = tok;
      if (m_acc) begin
        exp_q.push_back('{cyc + 1, d[7:0]});
        exp_q.push_back('{cyc + 2, d[15:8]});
        m_free = cyc + 2;
      end
    end
  endtask

  task automatic do_reset();
    tok_lvl = 0;
    step(0, 16'h0, 0, 1);
    step(0, 16'h0, 0, 1);
    mon_en = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'($urandom), tok_lvl, 0);
  endtask

  // Offers words continuously until n have been taken or the cycle budget runs out.
  task automatic send_words(input int n, input int budget, output int sent);
    logic [15:0] w;
    sent = 0;
    w = 16'($urandom);
    for (int i = 0; i < budget && sent < n; i++) begin
      step(1, w, tok_lvl, 0);
      if (m_acc) begin
        sent++;
        w = 16'($urandom);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        errors++;
        checks++;
        $display("FAIL missed_beat: got nothing expected %02h (cycle %0d)", exp_q[0].b, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        checks++;
        if (io_valid_o !== 1'b1 || io_data_o !== exp_q[0].b) begin
          errors++;
          $display("FAIL io_beat: got valid=%b data=%02h expected valid=1 data=%02h (cycle %0d)",
                   io_valid_o, io_data_o, exp_q[0].b, cyc);
        end
        void'(exp_q.pop_front());
      end else if (io_valid_o !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got valid=%b data=%02h expected valid=0 (cycle %0d)",
                 io_valid_o, io_data_o, cyc);
      end
    end
  end

  initial begin
    int sent;
    int cnt;

    do_reset();
    chk("reset_credit", int'(credit_o), 64);
    chk("reset_valid", int'(io_valid_o), 0);
    chk("reset_err", int'(credit_err_o), 0);

    // Single word A55A
    step(1, 16'hA55A, 0, 0);
    chk("a55a_yumi", int'(core_yumi_o), 1);
    step(0, 16'h0, 0, 0);
    chk("a55a_lo", int'(io_data_o), 8'h5A);
    chk("a55a_credit", int'(credit_o), 63);
    step(0, 16'h0, 0, 0);
    chk("a55a_hi", int'(io_data_o), 8'hA5);
    idle(2);

    // Back-to-back stream 1,2,3
    do_reset();
    cnt = 1;
    for (int i = 0; i < 20 && cnt <= 3; i++) begin
      step(1, 16'(cnt), 0, 0);
      if (m_acc) cnt++;
    end
    idle(4);
    chk("stream_credit", int'(credit_o), 61);

    // Exhaust credits, then one token returns four
    do_reset();
    send_words(64, 200, sent);
    chk("exhaust_sent", sent, 64);
    idle(3);
    chk("exhaust_credit", int'(credit_o), 0);
    step(1, 16'h1234, 0, 0);
    chk("exhaust_block", int'(core_yumi_o), 0);
    tok_lvl = 1;
    step(1, 16'h1234, tok_lvl, 0);
    chk("token_same_cycle_block", int'(core_yumi_o), 0);
    step(1, 16'h1234, tok_lvl, 0);
    chk("token_credit4", int'(credit_o) + 0, 4);
    cnt = int'(m_acc);
    for (int i = 0; i < 30; i++) begin
      step(1, 16'($urandom), tok_lvl, 0);
      cnt += int'(m_acc);
    end
    chk("token_words", cnt, 4);
    idle(3);

    // Spend and return in the same cycle at credit 10
    do_reset();
    send_words(54, 200, sent);
    idle(3);
    chk("c10_credit", int'(credit_o), 10);
    tok_lvl = 1;
    step(1, 16'h5555, tok_lvl, 0);
    chk("c10_yumi", int'(core_yumi_o), 1);
    step(0, 16'h0, tok_lvl, 0);
    chk("c10_after", int'(credit_o), 13);
    idle(3);

    // Saturation at 62 plus a token
    do_reset();
    send_words(2, 20, sent);
    idle(3);
    chk("c62_credit", int'(credit_o), 62);
    tok_lvl = 1;
    step(0, 16'h0, tok_lvl, 0);
    step(0, 16'h0, tok_lvl, 0);
    chk("sat_credit", int'(credit_o), 64);
    chk("sat_err", int'(credit_err_o), 1);
    send_words(3, 20, sent);
    idle(4);
    chk("sat_err_sticky", int'(credit_err_o), 1);

    // Reset while the low beat is on the pins
    step(1, 16'hBEEF, tok_lvl, 0);
    step(0, 16'h0, 0, 1);
    tok_lvl = 0;
    step(0, 16'h0, 0, 0);
    chk("midrst_valid", int'(io_valid_o), 0);
    chk("midrst_credit", int'(credit_o), 64);
    chk("midrst_err", int'(credit_err_o), 0);
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 12) tok_lvl = ~tok_lvl;
      if ($urandom_range(0, 199) == 0) begin
        step(0, 16'($urandom), 0, 1);
        tok_lvl = 0;
      end else begin
        step($urandom_range(0, 99) < 70, 16'($urandom), tok_lvl, 0);
      end
    end
    idle(4);
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
